// File: rtl/dbg_sba_axi_bridge_if.sv
// rtl/dbg_sba_axi_bridge_if.sv - AXI4 channel bundle between the SBA bridge (master) and one xbar slave port
interface dbg_sba_axi_bridge_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic                      aw_valid;
  logic                      aw_ready;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;

  logic                      w_valid;
  logic                      w_ready;
  logic [DATA_WIDTH-1:0]     w_data;
  logic [DATA_WIDTH/8-1:0]   w_strb;
  logic                      w_last;

  logic                      b_valid;
  logic                      b_ready;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;

  logic                      ar_valid;
  logic                      ar_ready;
  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;

  logic                      r_valid;
  logic                      r_ready;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [1:0]                r_resp;
  logic                      r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/dbg_sba_axi_bridge.sv
// rtl/dbg_sba_axi_bridge.sv - DM SBA req/gnt master port to single-beat AXI4 reads/writes
// Optional response timeout enabled by defining DBG_SBA_TIMEOUT_EN.
module dbg_sba_axi_bridge #(
  parameter int DATA_WIDTH     = 64,
  parameter int DM_ADDR_WIDTH  = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [DM_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [DATA_WIDTH/8-1:0]  be_i,
  output logic                     gnt_o,
  output logic                     r_valid_o,
  output logic [DATA_WIDTH-1:0]    r_rdata_o,
  output logic                     r_err_o,
  output logic                     r_other_err_o,
  output logic                     busy_o,
  dbg_sba_axi_bridge_if.master     axi
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_RD_REQ, S_WR_RESP, S_RD_RESP, S_ERR, S_DONE
  } state_e;

  localparam logic [2:0] AXI_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

  state_e                    r_state;
  state_e                    w_next;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_be;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic                      r_aw_sent;
  logic                      r_w_sent;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic                      r_err;
  logic                      r_other_err;

  logic w_grant;
  logic w_addr_oor;
  logic w_b_match;
  logic w_r_match;
  logic w_in_resp;
  logic w_timeout;

  generate
    if (DM_ADDR_WIDTH > AXI_ADDR_WIDTH) begin : g_range
      assign w_addr_oor = |addr_i[DM_ADDR_WIDTH-1:AXI_ADDR_WIDTH];
    end else begin : g_no_range
      assign w_addr_oor = 1'b0;
    end
  endgenerate

  assign w_grant   = req_i & (r_state == S_IDLE);
  assign w_b_match = axi.b_valid & (axi.b_id == r_id);
  assign w_r_match = axi.r_valid & (axi.r_id == r_id);
  assign w_in_resp = (r_state == S_WR_RESP) | (r_state == S_RD_RESP);

`ifdef DBG_SBA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_to_cnt <= '0;
    end else if (w_grant) begin
      r_to_cnt <= '0;
    end else if (w_in_resp) begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign w_timeout = w_in_resp & (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
  wire w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  wire w_unused_axi = ^{axi.r_last, axi.r_resp[0], axi.b_resp[0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A matching response in the same cycle as the timeout wins.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (w_addr_oor)  w_next = S_ERR;
          else if (we_i)   w_next = S_WR_REQ;
          else             w_next = S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        if ((r_aw_sent | axi.aw_ready) & (r_w_sent | axi.w_ready)) w_next = S_WR_RESP;
      end
      S_RD_REQ:  if (axi.ar_ready) w_next = S_RD_RESP;
      S_WR_RESP: if (w_b_match | w_timeout) w_next = S_DONE;
      S_RD_RESP: if (w_r_match | w_timeout) w_next = S_DONE;
      S_ERR:     w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_id        <= '0;
      r_aw_sent   <= 1'b0;
      r_w_sent    <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_other_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_addr      <= addr_i[AXI_ADDR_WIDTH-1:0];
        r_wdata     <= wdata_i;
        r_be        <= be_i;
        r_id        <= r_id + AXI_ID_WIDTH'(1);
        r_aw_sent   <= 1'b0;
        r_w_sent    <= 1'b0;
        r_rdata     <= '0;
        r_err       <= 1'b0;
        r_other_err <= w_addr_oor;
      end
      if (r_state == S_WR_REQ) begin
        if (axi.aw_ready) r_aw_sent <= 1'b1;
        if (axi.w_ready)  r_w_sent  <= 1'b1;
      end
      if ((r_state == S_WR_RESP) && w_b_match) begin
        r_err <= axi.b_resp[1];
      end else if ((r_state == S_RD_RESP) && w_r_match) begin
        r_err   <= axi.r_resp[1];
        r_rdata <= axi.r_data;
      end else if (w_timeout) begin
        r_other_err <= 1'b1;
      end
    end
  end

  // Stale beats (id != current) are always accepted so they never block the bus.
  always_comb begin
    gnt_o         = w_grant;
    busy_o        = (r_state != S_IDLE);
    r_valid_o     = (r_state == S_DONE);
    r_rdata_o     = r_valid_o ? r_rdata : '0;
    r_err_o       = r_valid_o & r_err;
    r_other_err_o = r_valid_o & r_other_err;

    axi.aw_valid  = (r_state == S_WR_REQ) & ~r_aw_sent;
    axi.aw_id     = r_id;
    axi.aw_addr   = r_addr;
    axi.aw_len    = 8'd0;
    axi.aw_size   = axi.aw_valid ? AXI_SIZE : 3'd0;
    axi.aw_burst  = axi.aw_valid ? 2'b01 : 2'b00;

    axi.w_valid   = (r_state == S_WR_REQ) & ~r_w_sent;
    axi.w_data    = r_wdata;
    axi.w_strb    = r_be;
    axi.w_last    = axi.w_valid;

    axi.b_ready   = (r_state == S_WR_RESP) | (axi.b_valid & (axi.b_id != r_id));

    axi.ar_valid  = (r_state == S_RD_REQ);
    axi.ar_id     = r_id;
    axi.ar_addr   = r_addr;
    axi.ar_len    = 8'd0;
    axi.ar_size   = axi.ar_valid ? AXI_SIZE : 3'd0;
    axi.ar_burst  = axi.ar_valid ? 2'b01 : 2'b00;

    axi.r_ready   = (r_state == S_RD_RESP) | (axi.r_valid & (axi.r_id != r_id));
  end

endmodule
